// File: rtl/bloom_hash_gen.sv
// Byte-stream front end for the Bloom-filter checker: four 16-bit rolling hash
// lanes per packet, folded to 8-bit indices and reported with a one-cycle hash_done.
module bloom_hash_gen #(
    parameter logic [15:0] SEED0   = 16'h9E37,
    parameter logic [15:0] SEED1   = 16'h85EB,
    parameter logic [15:0] SEED2   = 16'hC2B2,
    parameter logic [15:0] SEED3   = 16'h27D4,
    parameter logic [15:0] INIT    = 16'h0000,
    parameter int          MAX_LEN = 1518
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [7:0]  idx0,
    output logic [7:0]  idx1,
    output logic [7:0]  idx2,
    output logic [7:0]  idx3,
    output logic [15:0] pkt_len,
    output logic        trunc,
    output logic        hash_done
);

    typedef enum logic [2:0] {IDLE, ACCUM, FOLD, DONE, DRAIN} state_t;

    localparam logic [15:0] MAX_LEN_16 = 16'(MAX_LEN);

    state_t      state_reg, state_next;
    logic [15:0] len_cnt_reg;
    logic [15:0] pkt_len_reg;
    logic        trunc_flag_reg;
    logic        trunc_reg;
    logic        hash_done_reg;
    logic [31:0] idx_all;

    logic        accept;
    logic        hashing;
    logic [15:0] len_inc;
    logic        at_max;
    logic        closing;

    assign accept  = in_valid && in_ready;
    assign hashing = accept && ((state_reg == IDLE) || (state_reg == ACCUM));
    assign len_inc = len_cnt_reg + 16'd1;
    assign at_max  = (len_inc == MAX_LEN_16);
    assign closing = in_last || at_max;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, ACCUM: begin
                if (hashing) begin
                    state_next = closing ? FOLD : ACCUM;
                end
            end
            FOLD:    state_next = DONE;
            DONE:    state_next = trunc_flag_reg ? DRAIN : IDLE;
            DRAIN: begin
                if (accept && in_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        case (state_reg)
            IDLE, ACCUM, DRAIN: in_ready = 1'b1;
            default:            in_ready = 1'b0;
        endcase
    end

    // A byte that is both last and at MAX_LEN counts as a normal last (no drain).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_cnt_reg    <= '0;
            pkt_len_reg    <= '0;
            trunc_flag_reg <= 1'b0;
            trunc_reg      <= 1'b0;
            hash_done_reg  <= 1'b0;
        end else begin
            hash_done_reg <= (state_reg == FOLD);
            if (hashing) begin
                len_cnt_reg <= len_inc;
                if (closing) begin
                    trunc_flag_reg <= !in_last;
                end
            end else if (state_reg == DONE) begin
                len_cnt_reg <= '0;
            end
            if (state_reg == FOLD) begin
                pkt_len_reg <= len_cnt_reg;
                trunc_reg   <= trunc_flag_reg;
            end
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam logic [15:0] SEED = (gi == 0) ? SEED0 :
                                       (gi == 1) ? SEED1 :
                                       (gi == 2) ? SEED2 : SEED3;
        logic [15:0] lane_reg;
        logic [15:0] lane_next;
        logic [7:0]  idx_reg;

        assign lane_next = ({lane_reg[10:0], lane_reg[15:11]} ^ {8'h00, in_data}) + SEED;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                lane_reg <= INIT;
                idx_reg  <= '0;
            end else begin
                if (hashing) begin
                    lane_reg <= lane_next;
                end else if (state_reg == DONE) begin
                    lane_reg <= INIT;
                end
                if (state_reg == FOLD) begin
                    idx_reg <= lane_reg[15:8] ^ lane_reg[7:0];
                end
            end
        end

        assign idx_all[8*gi +: 8] = idx_reg;
    end

    assign idx0      = idx_all[7:0];
    assign idx1      = idx_all[15:8];
    assign idx2      = idx_all[23:16];
    assign idx3      = idx_all[31:24];
    assign pkt_len   = pkt_len_reg;
    assign trunc     = trunc_reg;
    assign hash_done = hash_done_reg;

endmodule

// File: tb/tb_bloom_hash_gen.sv
// Directed bench for bloom_hash_gen: default instance (a) and a MAX_LEN=4 instance (b)
// share clock, reset and data; each has its own in_valid.
module tb_bloom_hash_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_last;
    logic        va, vb;

    logic        rdy_a, hd_a, tr_a;
    logic [7:0]  i0a, i1a, i2a, i3a;
    logic [15:0] len_a;
    logic        rdy_b, hd_b, tr_b;
    logic [7:0]  i0b, i1b, i2b, i3b;
    logic [15:0] len_b;

    int n_tests = 0;
    int n_fail  = 0;
    int done_a  = 0;
    int done_b  = 0;

    always #5 clk = ~clk;

    bloom_hash_gen dut_a (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(va), .in_last(in_last),
        .in_ready(rdy_a), .idx0(i0a), .idx1(i1a), .idx2(i2a), .idx3(i3a),
        .pkt_len(len_a), .trunc(tr_a), .hash_done(hd_a)
    );

    bloom_hash_gen #(.MAX_LEN(4)) dut_b (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(vb), .in_last(in_last),
        .in_ready(rdy_b), .idx0(i0b), .idx1(i1b), .idx2(i2b), .idx3(i3b),
        .pkt_len(len_b), .trunc(tr_b), .hash_done(hd_b)
    );

    always @(negedge clk) begin
        if (hd_a) done_a++;
        if (hd_b) done_b++;
    end

    typedef struct {
        int          n;
        logic [63:0] bytes;
        logic [31:0] exp;
        logic [15:0] len;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("[TB] ok %s = %0h", name, act);
        end
    endtask

    function automatic logic [31:0] model(input logic [63:0] bs, input int n);
        logic [15:0] h;
        logic [15:0] sd;
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            case (k)
                0:       sd = 16'h9E37;
                1:       sd = 16'h85EB;
                2:       sd = 16'hC2B2;
                default: sd = 16'h27D4;
            endcase
            h = 16'h0000;
            for (int i = 0; i < n; i++) begin
                h = ({h[10:0], h[15:11]} ^ {8'h00, bs[8*i +: 8]}) + sd;
            end
            r[8*k +: 8] = h[15:8] ^ h[7:0];
        end
        return r;
    endfunction

    task automatic send_byte(input int sel, input logic [7:0] d, input logic l);
        logic r;
        in_data = d;
        in_last = l;
        if (sel == 0) va = 1'b1; else vb = 1'b1;
        for (int k = 0; k < 20; k++) begin
            r = (sel == 0) ? rdy_a : rdy_b;
            @(posedge clk); #1;
            if (r) begin
                va = 1'b0; vb = 1'b0;
                return;
            end
        end
        va = 1'b0; vb = 1'b0;
        chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done(input int sel, output int cyc);
        cyc = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if ((sel == 0) ? hd_a : hd_b) begin
                cyc = k;
                return;
            end
        end
        chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_res(input int sel, input string tag, input logic [31:0] e,
                             input logic [15:0] len, input logic tr);
        if (sel == 0) begin
            chk({tag, "_idx"}, {i3a, i2a, i1a, i0a}, e);
            chk({tag, "_len"}, 32'(len_a), 32'(len));
            chk({tag, "_trunc"}, 32'(tr_a), 32'(tr));
        end else begin
            chk({tag, "_idx"}, {i3b, i2b, i1b, i0b}, e);
            chk({tag, "_len"}, 32'(len_b), 32'(len));
            chk({tag, "_trunc"}, 32'(tr_b), 32'(tr));
        end
    endtask

    initial begin
        int cyc;
        int d0;
        logic [31:0] e_gap;

        vecs[0] = '{n: 1, bytes: 64'h00,   exp: 32'hF3706EA9, len: 16'd1};
        vecs[1] = '{n: 1, bytes: 64'h01,   exp: 32'hF27169A6, len: 16'd1};
        vecs[2] = '{n: 2, bytes: 64'h0000, exp: 32'h7A13184F, len: 16'd2};
        vecs[3] = '{n: 2, bytes: 64'h0000, exp: 32'h7A13184F, len: 16'd2};

        rst = 1'b1; va = 1'b0; vb = 1'b0; in_data = 8'h00; in_last = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        chk("reset_idx_a", {i3a, i2a, i1a, i0a}, 32'h0);
        chk("reset_len_a", 32'(len_a), 32'h0);
        chk("reset_trunc_done_a", {30'h0, tr_a, hd_a}, 32'h0);
        chk("reset_ready_a", 32'(rdy_a), 32'h1);
        chk("reset_ready_b", 32'(rdy_b), 32'h1);

        // Table-driven packets with latency / in_ready window checks.
        for (int v = 0; v < 4; v++) begin
            d0 = done_a;
            for (int i = 0; i < vecs[v].n; i++) begin
                send_byte(0, vecs[v].bytes[8*i +: 8], (i == vecs[v].n - 1));
            end
            chk("ready_fold", 32'(rdy_a), 32'h0);
            wait_done(0, cyc);
            chk("done_latency", 32'(cyc), 32'd1);
            chk("ready_done", 32'(rdy_a), 32'h0);
            check_res(0, "vec", vecs[v].exp, vecs[v].len, 1'b0);
            @(posedge clk); #1;
            chk("done_one_cycle", 32'(hd_a), 32'h0);
            chk("ready_back", 32'(rdy_a), 32'h1);
            chk("done_count", 32'(done_a - d0), 32'd1);
        end

        // in_valid toggled every cycle across a 3-byte packet.
        e_gap = model(64'h563412, 3);
        send_byte(0, 8'h12, 1'b0); @(posedge clk); #1;
        send_byte(0, 8'h34, 1'b0); @(posedge clk); #1;
        send_byte(0, 8'h56, 1'b1);
        wait_done(0, cyc);
        check_res(0, "gap", e_gap, 16'd3, 1'b0);
        @(posedge clk); #1;

        // Same packet gap-free, with the next byte held valid through FOLD/DONE.
        send_byte(0, 8'h12, 1'b0);
        send_byte(0, 8'h34, 1'b0);
        send_byte(0, 8'h56, 1'b1);
        in_data = 8'h01; in_last = 1'b1; va = 1'b1;
        @(posedge clk); #1;
        chk("b2b_done", 32'(hd_a), 32'h1);
        check_res(0, "b2b", e_gap, 16'd3, 1'b0);
        @(posedge clk); #1;
        chk("b2b_ready", 32'(rdy_a), 32'h1);
        @(posedge clk); #1;
        va = 1'b0;
        chk("b2b_accepted", 32'(rdy_a), 32'h0);
        wait_done(0, cyc);
        check_res(0, "b2b_next", 32'hF27169A6, 16'd1, 1'b0);
        @(posedge clk); #1;

        // MAX_LEN=4: 6-byte packet truncated after byte 4, bytes 5-6 drained.
        d0 = done_b;
        for (int i = 0; i < 4; i++) send_byte(1, 8'h00, 1'b0);
        wait_done(1, cyc);
        check_res(1, "trunc", model(64'h0, 4), 16'd4, 1'b1);
        send_byte(1, 8'h00, 1'b0);
        send_byte(1, 8'h00, 1'b1);
        repeat (4) @(posedge clk); #1;
        chk("drain_no_pulse", 32'(done_b - d0), 32'd1);
        send_byte(1, 8'h00, 1'b1);
        wait_done(1, cyc);
        check_res(1, "after_drain", 32'hF3706EA9, 16'd1, 1'b0);
        @(posedge clk); #1;

        // MAX_LEN=4: last on byte 4 is a normal last, no drain follows.
        for (int i = 0; i < 4; i++) send_byte(1, 8'h00, (i == 3));
        wait_done(1, cyc);
        check_res(1, "last_at_max", model(64'h0, 4), 16'd4, 1'b0);
        @(posedge clk); #1;
        send_byte(1, 8'h01, 1'b1);
        wait_done(1, cyc);
        check_res(1, "no_drain", 32'hF27169A6, 16'd1, 1'b0);
        @(posedge clk); #1;

        // Asynchronous reset mid-packet.
        d0 = done_a;
        send_byte(0, 8'h55, 1'b0);
        send_byte(0, 8'h66, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst_idx", {i3a, i2a, i1a, i0a}, 32'h0);
        chk("arst_len_trunc", {15'h0, len_a, tr_a}, 32'h0);
        @(negedge clk) rst = 1'b0;
        repeat (4) @(posedge clk); #1;
        chk("arst_no_done", 32'(done_a - d0), 32'd0);
        chk("arst_ready", 32'(rdy_a), 32'h1);
        send_byte(0, 8'h00, 1'b1);
        wait_done(0, cyc);
        check_res(0, "post_rst", 32'hF3706EA9, 16'd1, 1'b0);
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
